// File: rtl/mcca_defs.sv
// ---------------------------------------------------------------------------
// mcca_defs
//  Definitions shared by the MCCA (Manchester carry-chain adder) family.
//  - state_t  : 2-bit FSM encoding IDLE / PRECH / EVAL / DONE
//  - nblk_f   : number of chain segments for a SIZE/BLK pair
//  - idxw_f   : width of a segment index counter (never below 1 bit)
// ---------------------------------------------------------------------------
package mcca_defs;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRECH = 2'd1,
        EVAL  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Guarded so an illegal BLK reaches the elaboration check instead of a divide-by-zero.
    function automatic int nblk_f(input int size, input int blk);
        return (blk < 1) ? 1 : size / blk;
    endfunction

    function automatic int idxw_f(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mcc_chain_seg.sv
// ---------------------------------------------------------------------------
// mcc_chain_seg
//  Combinational model of one BLK-bit Manchester carry-chain segment.
//  Ports:
//    p        in  BLK  propagate bits (a ^ b)
//    g        in  BLK  generate bits  (a & b)
//    cin      in  1    carry into the segment
//    s        out BLK  sum bits
//    cout     out 1    carry out of the segment
//    c_msb_in out 1    carry into the segment's top bit (for overflow)
//    pall     out 1    every bit of the segment propagates
// ---------------------------------------------------------------------------
module mcc_chain_seg #(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] p,
    input  logic [BLK-1:0] g,
    input  logic           cin,
    output logic [BLK-1:0] s,
    output logic           cout,
    output logic           c_msb_in,
    output logic           pall
);

    logic [BLK:0] w_c;

    assign w_c[0] = cin;

    generate
        for (genvar gi = 0; gi < BLK; gi++) begin : g_bit
            assign w_c[gi+1] = g[gi] | (p[gi] & w_c[gi]);
            assign s[gi]     = p[gi] ^ w_c[gi];
        end
    endgenerate

    assign cout     = w_c[BLK];
    assign c_msb_in = w_c[BLK-1];
    assign pall     = &p;

endmodule

// File: rtl/mcca_seq_adder.sv
// ---------------------------------------------------------------------------
// mcca_seq_adder
//  Clocked Manchester carry-chain adder. Each add runs one PRECH cycle, then
//  one EVAL cycle per BLK-bit segment, then presents the result in DONE.
//  Ports:
//    clk       in  1     clock, rising edge
//    rst_n     in  1     asynchronous active-low reset
//    in_valid  in  1     operands a/b/cin presented
//    in_ready  out 1     operands can be accepted (IDLE only)
//    a, b      in  SIZE  operands
//    cin       in  1     carry in
//    out_valid out 1     result valid, held until out_ready
//    out_ready in  1     sink accepts result
//    sum       out SIZE  a+b+cin modulo 2^SIZE
//    cout      out 1     carry out of MSB
//    ovf       out 1     signed overflow
//    prop_all  out 1     every bit propagates (cout == cin)
// ---------------------------------------------------------------------------
module mcca_seq_adder
    import mcca_defs::*;
#(
    parameter int SIZE = 16,
    parameter int BLK  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            cin,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] sum,
    output logic            cout,
    output logic            ovf,
    output logic            prop_all
);

    localparam int BLK_S = (BLK < 1) ? 1 : BLK;
    localparam int NBLK  = nblk_f(SIZE, BLK);
    localparam int IDXW  = idxw_f(NBLK);
    localparam int SW    = (SIZE <= 1) ? 1 : $clog2(SIZE);

    generate
        if (BLK < 1 || (SIZE % BLK_S) != 0) begin : g_bad_param
            $error("mcca_seq_adder: BLK must be >= 1 and divide SIZE");
        end
    endgenerate

    state_t            r_state;
    logic [SIZE-1:0]   r_a;
    logic [SIZE-1:0]   r_b;
    logic              r_cin;
    logic [IDXW-1:0]   r_idx;
    logic              r_carry;
    logic [SIZE-1:0]   r_sum;
    logic              r_cout;
    logic              r_ovf;
    logic              r_pall;
    logic              r_in_ready;
    logic              r_out_valid;

    logic [SW-1:0]     w_base;
    logic [BLK_S-1:0]  w_p;
    logic [BLK_S-1:0]  w_g;
    logic [BLK_S-1:0]  w_s;
    logic              w_seg_cout;
    logic              w_c_msb_in;
    logic              w_seg_pall;
    logic              w_last;

    // Low bit of the segment currently being evaluated.
    assign w_base = SW'(r_idx * BLK_S);
    assign w_p    = r_a[w_base +: BLK_S] ^ r_b[w_base +: BLK_S];
    assign w_g    = r_a[w_base +: BLK_S] & r_b[w_base +: BLK_S];
    assign w_last = (r_idx == IDXW'(NBLK - 1));

    mcc_chain_seg #(
        .BLK (BLK_S)
    ) u_seg (
        .p        (w_p),
        .g        (w_g),
        .cin      (r_carry),
        .s        (w_s),
        .cout     (w_seg_cout),
        .c_msb_in (w_c_msb_in),
        .pall     (w_seg_pall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_cin       <= 1'b0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_pall      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_cin      <= cin;
                        r_in_ready <= 1'b0;
                        r_state    <= PRECH;
                    end
                end
                PRECH: begin
                    r_sum   <= '0;
                    r_idx   <= '0;
                    r_carry <= r_cin;
                    r_pall  <= 1'b1;
                    r_state <= EVAL;
                end
                EVAL: begin
                    r_sum[w_base +: BLK_S] <= w_s;
                    r_carry <= w_seg_cout;
                    r_pall  <= r_pall & w_seg_pall;
                    if (w_last) begin
                        // Top segment: its carry into the top bit is the word's carry into MSB.
                        r_cout      <= w_seg_cout;
                        r_ovf       <= w_c_msb_in ^ w_seg_cout;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign prop_all  = r_pall;

endmodule

// File: tb/tb_mcca_seq_adder.sv
// ---------------------------------------------------------------------------
// tb_mcca_seq_adder
//  Three adders (BLK = 1, 4, 16 at SIZE = 16) share clock and reset.
//  Instance 1 (BLK=4) takes the directed table and the multi-cycle sequences;
//  all three take random operands checked against plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_mcca_seq_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [15:0] a_i       [3];
    logic [15:0] b_i       [3];
    logic        cin_i     [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [15:0] sum_o     [3];
    logic        cout_o    [3];
    logic        ovf_o     [3];
    logic        pall_o    [3];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            mcca_seq_adder #(
                .SIZE (16),
                .BLK  (gi == 0 ? 1 : (gi == 1 ? 4 : 16))
            ) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid[gi]),
                .in_ready  (in_ready[gi]),
                .a         (a_i[gi]),
                .b         (b_i[gi]),
                .cin       (cin_i[gi]),
                .out_valid (out_valid[gi]),
                .out_ready (out_ready[gi]),
                .sum       (sum_o[gi]),
                .cout      (cout_o[gi]),
                .ovf       (ovf_o[gi]),
                .prop_all  (pall_o[gi])
            );
        end
    endgenerate

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        co;
        logic        ov;
        logic        pa;
    } vec_t;

    vec_t tbl [7];

    function automatic int blk_of(input int j);
        return (j == 0) ? 1 : ((j == 1) ? 4 : 16);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Reference: the adder's contract in whole-word integer arithmetic.
    task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic mc,
                         output logic [15:0] s, output logic co, output logic ov,
                         output logic pa);
        logic [16:0] t;
        t  = {1'b0, ma} + {1'b0, mb} + {16'd0, mc};
        s  = t[15:0];
        co = t[16];
        ov = (ma[15] == mb[15]) && (s[15] != ma[15]);
        pa = ((ma ^ mb) == 16'hFFFF);
    endtask

    // Called just after the accept edge; lat counts the accept cycle as 0.
    task automatic wait_done(input int j, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid[j] && lat < 100);
        if (!out_valid[j]) lat = -1;
    endtask

    task automatic finish_op(input int j);
        out_ready[j] = 1'b1;
        @(posedge clk);
        #1 out_ready[j] = 1'b0;
        @(negedge clk);
        check("out_valid_drop", {31'd0, out_valid[j]}, 32'd0);
    endtask

    task automatic run_op(input int j, input logic [15:0] ta, input logic [15:0] tb,
                          input logic tc, output logic [15:0] s, output logic co,
                          output logic ov, output logic pa, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready[j] && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        a_i[j] = ta; b_i[j] = tb; cin_i[j] = tc; in_valid[j] = 1'b1;
        @(posedge clk);
        // Port operands are free to change once accepted.
        #1 in_valid[j] = 1'b0;
        a_i[j] = 16'($urandom); b_i[j] = 16'($urandom); cin_i[j] = 1'($urandom);
        wait_done(j, lat);
        s = sum_o[j]; co = cout_o[j]; ov = ovf_o[j]; pa = pall_o[j];
        $display("op blk=%0d a=%h b=%h cin=%0b -> sum=%h cout=%0b ovf=%0b pall=%0b lat=%0d",
                 blk_of(j), ta, tb, tc, s, co, ov, pa, lat);
        finish_op(j);
    endtask

    initial begin
        logic [15:0] s, es, ra, rb;
        logic        co, ov, pa, eco, eov, epa, rc;
        int          lat;
        int          stray;

        tbl[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{16'h5555, 16'hAAAA, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1};

        for (int j = 0; j < 3; j++) begin
            in_valid[j] = 1'b0; out_ready[j] = 1'b0;
            a_i[j] = '0; b_i[j] = '0; cin_i[j] = 1'b0;
        end

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  {31'd0, in_ready[1]},  32'd1);
        check("rst_out_valid", {31'd0, out_valid[1]}, 32'd0);
        check("rst_sum",       {16'd0, sum_o[1]},     32'd0);
        check("rst_cout",      {31'd0, cout_o[1]},    32'd0);
        check("rst_ovf",       {31'd0, ovf_o[1]},     32'd0);
        check("rst_prop_all",  {31'd0, pall_o[1]},    32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", {31'd0, in_ready[1]},  32'd1);
        check("idle_out_valid", {31'd0, out_valid[1]}, 32'd0);

        // Directed table on BLK=4
        for (int i = 0; i < 7; i++) begin
            run_op(1, tbl[i].a, tbl[i].b, tbl[i].cin, s, co, ov, pa, lat);
            check("tbl_sum",      {16'd0, s},  {16'd0, tbl[i].s});
            check("tbl_cout",     {31'd0, co}, {31'd0, tbl[i].co});
            check("tbl_ovf",      {31'd0, ov}, {31'd0, tbl[i].ov});
            check("tbl_prop_all", {31'd0, pa}, {31'd0, tbl[i].pa});
            check("tbl_latency",  32'(lat),    32'd6);
        end

        // Backpressure with a competing operand set presented meanwhile
        @(negedge clk);
        a_i[1] = 16'h00FF; b_i[1] = 16'h0001; cin_i[1] = 1'b0; in_valid[1] = 1'b1;
        @(posedge clk);
        #1 in_valid[1] = 1'b0;
        wait_done(1, lat);
        check("bp_latency", 32'(lat), 32'd6);
        a_i[1] = 16'h0003; b_i[1] = 16'h0005; cin_i[1] = 1'b0; in_valid[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_out_valid", {31'd0, out_valid[1]}, 32'd1);
            check("bp_in_ready",  {31'd0, in_ready[1]},  32'd0);
            check("bp_sum",       {16'd0, sum_o[1]},     32'h0100);
        end
        $display("op blk=4 a=00ff b=0001 cin=0 held 5 cycles -> sum=%h", sum_o[1]);
        out_ready[1] = 1'b1;
        @(posedge clk);
        #1 out_ready[1] = 1'b0;
        @(negedge clk);
        check("bp_release_valid", {31'd0, out_valid[1]}, 32'd0);
        check("bp_release_ready", {31'd0, in_ready[1]},  32'd1);
        @(posedge clk);
        #1 in_valid[1] = 1'b0;
        wait_done(1, lat);
        check("bp_next_latency", 32'(lat), 32'd6);
        check("bp_next_sum", {16'd0, sum_o[1]}, 32'd8);
        $display("op blk=4 a=0003 b=0005 cin=0 (queued) -> sum=%h lat=%0d", sum_o[1], lat);
        finish_op(1);

        // Reset while evaluating segment 2
        @(negedge clk);
        a_i[1] = 16'hFFFF; b_i[1] = 16'h0001; cin_i[1] = 1'b0; in_valid[1] = 1'b1;
        @(posedge clk);
        #1 in_valid[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", {31'd0, out_valid[1]}, 32'd0);
        check("mid_rst_in_ready",  {31'd0, in_ready[1]},  32'd1);
        check("mid_rst_sum",       {16'd0, sum_o[1]},     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid[1]) stray++;
        end
        check("mid_rst_no_valid", 32'(stray), 32'd0);
        $display("op blk=4 a=ffff b=0001 cin=0 abandoned by reset");
        run_op(1, 16'd3, 16'd5, 1'b0, s, co, ov, pa, lat);
        check("post_rst_sum",     {16'd0, s}, 32'd8);
        check("post_rst_latency", 32'(lat),   32'd6);

        // Random sweep over BLK = 1, 4, 16
        for (int j = 0; j < 3; j++) begin
            for (int n = 0; n < 1000; n++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                rc = 1'($urandom_range(0, 1));
                if (n % 8 == 0) rb = ~ra;
                run_op(j, ra, rb, rc, s, co, ov, pa, lat);
                model(ra, rb, rc, es, eco, eov, epa);
                check("rnd_sum",      {16'd0, s},  {16'd0, es});
                check("rnd_cout",     {31'd0, co}, {31'd0, eco});
                check("rnd_ovf",      {31'd0, ov}, {31'd0, eov});
                check("rnd_prop_all", {31'd0, pa}, {31'd0, epa});
                check("rnd_latency",  32'(lat),    32'(16 / blk_of(j) + 2));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
